// File: rtl/clb_config_frame_loader.sv
// Serial config frame loader for one CLB: shifts the bitstream while holding the daisy-chain token, then commits to a shadow register.
// Optional FRAME_PARITY_EN appends an even-parity bit per frame and blocks the commit of a frame that fails it.
module clb_config_frame_loader #(
    parameter int NUM_LUT_IN = 4,
    parameter int SEL_W      = 6,
    parameter int CYGEN_W    = 3
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        bit_in,
    input  logic                        prgm_b,
    input  logic                        CLB_prgm_b,
    input  logic                        CLB_prgm_b_in,
    output logic                        CLB_prgm_b_out,
    output logic                        config_data_out,
    output logic [NUM_LUT_IN*SEL_W-1:0] interconnect_config,
    output logic [SEL_W-1:0]            Bypass_inp_conf,
    output logic [SEL_W-1:0]            data_line_conf,
    output logic [CYGEN_W-1:0]          CY_GEN_MUX,
    output logic                        CYO_SEL_MUX,
    output logic                        SUM_LUT_SEL_MUX,
    output logic                        DFF_INP_SEL_MUX,
    output logic                        config_valid,
    output logic                        frame_err,
    output logic [1:0]                  state_dbg
);
    localparam int FRAME_LEN = NUM_LUT_IN*SEL_W + 2*SEL_W + CYGEN_W + 3;
`ifdef FRAME_PARITY_EN
    localparam int FW = FRAME_LEN + 1;
`else
    localparam int FW = FRAME_LEN;
`endif
    localparam int CNT_W = $clog2(FRAME_LEN + 2);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FW - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        DONE   = 2'd2,
        COMMIT = 2'd3
    } state_t;

    state_t               state;
    logic [CNT_W-1:0]     count;
    logic [FW-1:0]        frame;
    logic [FRAME_LEN-1:0] shadow;
    logic                 shift_en;
    logic [FW-1:0]        frame_next;

    // Handshake: a bit is consumed on every clock edge where the array enable and
    // the upstream token are both high; dropping either pauses without losing data.
    assign shift_en   = CLB_prgm_b & CLB_prgm_b_in;
    assign frame_next = {frame[FW-2:0], bit_in};
    assign state_dbg  = state;

`ifdef FRAME_PARITY_EN
    logic parity_err;
    assign frame_err = parity_err;
`else
    assign frame_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= IDLE;
            count           <= '0;
            frame           <= '0;
            shadow          <= '0;
            config_valid    <= 1'b0;
            CLB_prgm_b_out  <= 1'b0;
            config_data_out <= 1'b0;
`ifdef FRAME_PARITY_EN
            parity_err      <= 1'b0;
`endif
        end else begin
            config_data_out <= frame[FW-1];
            case (state)
                IDLE: begin
                    if (!prgm_b && shift_en) begin
                        frame <= frame_next;
                        count <= CNT_W'(1);
                        state <= SHIFT;
`ifdef FRAME_PARITY_EN
                        parity_err <= 1'b0;
`endif
                    end
                end
                SHIFT: begin
                    if (prgm_b) begin
                        // Stream ended before a full frame arrived: drop the partial load.
                        state <= IDLE;
                        count <= '0;
                    end else if (shift_en) begin
                        frame <= frame_next;
                        count <= count + 1'b1;
                        if (count == LAST_CNT) begin
                            state <= DONE;
`ifdef FRAME_PARITY_EN
                            parity_err <= ^frame_next;
`endif
                        end
                    end
                end
                DONE: begin
                    CLB_prgm_b_out <= 1'b1;
                    if (prgm_b && !CLB_prgm_b) begin
                        state <= COMMIT;
                    end
                end
                COMMIT: begin
`ifdef FRAME_PARITY_EN
                    if (!parity_err) begin
                        shadow       <= frame[FW-1:1];
                        config_valid <= 1'b1;
                    end
`else
                    shadow       <= frame;
                    config_valid <= 1'b1;
`endif
                    CLB_prgm_b_out <= 1'b0;
                    count          <= '0;
                    state          <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // First bit received lands in the MSB; the last bit ends up in interconnect_config[0].
    assign DFF_INP_SEL_MUX     = shadow[FRAME_LEN-1];
    assign SUM_LUT_SEL_MUX     = shadow[FRAME_LEN-2];
    assign CYO_SEL_MUX         = shadow[FRAME_LEN-3];
    assign CY_GEN_MUX          = shadow[FRAME_LEN-4 -: CYGEN_W];
    assign Bypass_inp_conf     = shadow[FRAME_LEN-4-CYGEN_W -: SEL_W];
    assign data_line_conf      = shadow[FRAME_LEN-4-CYGEN_W-SEL_W -: SEL_W];
    assign interconnect_config = shadow[NUM_LUT_IN*SEL_W-1:0];

endmodule

// File: tb/tb_clb_config_frame_loader.sv
// Bench for clb_config_frame_loader: two instances (second chained on the first's token), scoreboarded frame commits.
module tb_clb_config_frame_loader;
    localparam int FL = 42;
`ifdef FRAME_PARITY_EN
    localparam int FW = FL + 1;
`else
    localparam int FW = FL;
`endif

    logic clk = 1'b0;
    logic reset, bit_in, prgm_b, clb_prgm_b, tok_in, chain_mode;
    logic tok_in1;

    logic        tok0, cdo0, cyo0, sum0, dff0, valid0, err0;
    logic [23:0] ic0;
    logic [5:0]  byp0, dl0;
    logic [2:0]  cy0;
    logic [1:0]  st0;
    logic        tok1, cdo1, cyo1, sum1, dff1, valid1, err1;
    logic [23:0] ic1;
    logic [5:0]  byp1, dl1;
    logic [2:0]  cy1;
    logic [1:0]  st1;

    logic [FL-1:0] cfg0, cfg1;
    assign cfg0    = {dff0, sum0, cyo0, cy0, byp0, dl0, ic0};
    assign cfg1    = {dff1, sum1, cyo1, cy1, byp1, dl1, ic1};
    assign tok_in1 = chain_mode & tok0;

    int checks   = 0;
    int failures = 0;
    logic [FL-1:0] exp_q[$];
    logic [FL-1:0] last_cfg;

    always #5 clk = ~clk;

    clb_config_frame_loader u0 (
        .clk(clk), .reset(reset), .bit_in(bit_in), .prgm_b(prgm_b),
        .CLB_prgm_b(clb_prgm_b), .CLB_prgm_b_in(tok_in), .CLB_prgm_b_out(tok0),
        .config_data_out(cdo0), .interconnect_config(ic0), .Bypass_inp_conf(byp0),
        .data_line_conf(dl0), .CY_GEN_MUX(cy0), .CYO_SEL_MUX(cyo0),
        .SUM_LUT_SEL_MUX(sum0), .DFF_INP_SEL_MUX(dff0), .config_valid(valid0),
        .frame_err(err0), .state_dbg(st0)
    );

    clb_config_frame_loader u1 (
        .clk(clk), .reset(reset), .bit_in(bit_in), .prgm_b(prgm_b),
        .CLB_prgm_b(clb_prgm_b), .CLB_prgm_b_in(tok_in1), .CLB_prgm_b_out(tok1),
        .config_data_out(cdo1), .interconnect_config(ic1), .Bypass_inp_conf(byp1),
        .data_line_conf(dl1), .CY_GEN_MUX(cy1), .CYO_SEL_MUX(cyo1),
        .SUM_LUT_SEL_MUX(sum1), .DFF_INP_SEL_MUX(dff1), .config_valid(valid1),
        .frame_err(err1), .state_dbg(st1)
    );

    function automatic logic [FW-1:0] mk_frame(input logic [FL-1:0] d);
`ifdef FRAME_PARITY_EN
        return {d, ^d};
`else
        return d;
`endif
    endfunction

    function automatic logic [FL-1:0] rand_cfg();
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        return r[FL-1:0];
    endfunction

    // Drivers: inputs change just after a negedge, the DUT samples on the posedge.
    task automatic do_reset();
        reset = 1'b1; prgm_b = 1'b1; clb_prgm_b = 1'b0; tok_in = 1'b0; bit_in = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic drive_frame(input logic [FW-1:0] f, input int nbits,
                               input int pause_at, input int pause_len);
        prgm_b = 1'b0; clb_prgm_b = 1'b1; tok_in = 1'b1;
        for (int i = 0; i < nbits; i++) begin
            bit_in = f[FW-1-i];
            @(negedge clk);
            if (i + 1 == pause_at) begin
                tok_in = 1'b0;
                bit_in = 1'($urandom_range(0, 1));
                repeat (pause_len) @(negedge clk);
                tok_in = 1'b1;
            end
        end
    endtask

    task automatic commit_frame();
        prgm_b = 1'b1; clb_prgm_b = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        chain_mode = 1'b0;
        reset = 1'b1; prgm_b = 1'b0; clb_prgm_b = 1'b1; tok_in = 1'b1; bit_in = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (cfg0 !== '0)     begin failures++; $display("FAIL reset_cfg got=%h exp=0", cfg0); end
        checks++; if (valid0 !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", valid0); end
        checks++; if (tok0 !== 1'b0)   begin failures++; $display("FAIL reset_tok got=%b exp=0", tok0); end
        checks++; if (cdo0 !== 1'b0)   begin failures++; $display("FAIL reset_cdo got=%b exp=0", cdo0); end
        checks++; if (err0 !== 1'b0)   begin failures++; $display("FAIL reset_err got=%b exp=0", err0); end
        checks++; if (st0 !== 2'd0)    begin failures++; $display("FAIL reset_state got=%0d exp=0", st0); end
        reset = 1'b0;
    endtask

    task automatic test_basic();
        logic [FL-1:0] d, e;
        d = 42'h2AA_AAAA_AAAA;
        exp_q.push_back(d);
        drive_frame(mk_frame(d), FW, 0, 0);
        checks++; if (st0 !== 2'd2) begin failures++; $display("FAIL basic_done got=%0d exp=2", st0); end
        checks++; if (tok0 !== 1'b0) begin failures++; $display("FAIL basic_tok_early got=%b exp=0", tok0); end
        @(negedge clk);
        checks++; if (tok0 !== 1'b1) begin failures++; $display("FAIL basic_tok got=%b exp=1", tok0); end
        checks++; if (cdo0 !== 1'b1) begin failures++; $display("FAIL basic_cdo got=%b exp=1", cdo0); end
        prgm_b = 1'b1; clb_prgm_b = 1'b0;
        @(negedge clk);
        checks++; if (st0 !== 2'd3)    begin failures++; $display("FAIL basic_commit_state got=%0d exp=3", st0); end
        checks++; if (valid0 !== 1'b0) begin failures++; $display("FAIL basic_valid_early got=%b exp=0", valid0); end
        @(negedge clk);
        checks++; if (valid0 !== 1'b1) begin failures++; $display("FAIL basic_valid got=%b exp=1", valid0); end
        checks++; if (dff0 !== 1'b1)   begin failures++; $display("FAIL basic_dff got=%b exp=1", dff0); end
        checks++; if (ic0[0] !== 1'b0) begin failures++; $display("FAIL basic_ic0 got=%b exp=0", ic0[0]); end
        checks++; if (tok0 !== 1'b0)   begin failures++; $display("FAIL basic_tok_clear got=%b exp=0", tok0); end
        e = exp_q.pop_front();
        checks++; if (cfg0 !== e) begin failures++; $display("FAIL basic_cfg got=%h exp=%h", cfg0, e); end
        last_cfg = e;
    endtask

    task automatic test_chain();
        logic [FL-1:0] d0, d1, e;
        do_reset();
        chain_mode = 1'b1;
        d0 = rand_cfg(); d1 = rand_cfg();
        exp_q.push_back(d0); exp_q.push_back(d1);
        drive_frame(mk_frame(d0), FW, 0, 0);
        bit_in = 1'($urandom_range(0, 1));
        @(negedge clk);
        checks++; if (tok0 !== 1'b1) begin failures++; $display("FAIL chain_tok0 got=%b exp=1", tok0); end
        checks++; if (st1 !== 2'd0)  begin failures++; $display("FAIL chain_u1_idle got=%0d exp=0", st1); end
        drive_frame(mk_frame(d1), FW, 0, 0);
        checks++; if (st1 !== 2'd2) begin failures++; $display("FAIL chain_u1_done got=%0d exp=2", st1); end
        commit_frame();
        e = exp_q.pop_front();
        checks++; if (cfg0 !== e) begin failures++; $display("FAIL chain_cfg0 got=%h exp=%h", cfg0, e); end
        e = exp_q.pop_front();
        checks++; if (cfg1 !== e) begin failures++; $display("FAIL chain_cfg1 got=%h exp=%h", cfg1, e); end
        checks++; if (valid1 !== 1'b1) begin failures++; $display("FAIL chain_valid1 got=%b exp=1", valid1); end
        chain_mode = 1'b0;
        last_cfg = d0;
    endtask

    task automatic test_pause();
        logic [FL-1:0] d, e;
        d = rand_cfg();
        exp_q.push_back(d);
        drive_frame(mk_frame(d), FW, 10, 5);
        checks++; if (st0 !== 2'd2) begin failures++; $display("FAIL pause_done got=%0d exp=2", st0); end
        commit_frame();
        e = exp_q.pop_front();
        checks++; if (cfg0 !== e) begin failures++; $display("FAIL pause_cfg got=%h exp=%h", cfg0, e); end
        last_cfg = e;
    endtask

    task automatic test_abort();
        logic [FL-1:0] d, e;
        drive_frame(mk_frame(rand_cfg()), 20, 0, 0);
        prgm_b = 1'b1;
        @(negedge clk);
        checks++; if (st0 !== 2'd0)     begin failures++; $display("FAIL abort_state got=%0d exp=0", st0); end
        checks++; if (tok0 !== 1'b0)    begin failures++; $display("FAIL abort_tok got=%b exp=0", tok0); end
        checks++; if (cfg0 !== last_cfg) begin failures++; $display("FAIL abort_cfg got=%h exp=%h", cfg0, last_cfg); end
        checks++; if (valid0 !== 1'b1)  begin failures++; $display("FAIL abort_valid got=%b exp=1", valid0); end
        d = rand_cfg();
        exp_q.push_back(d);
        drive_frame(mk_frame(d), FW, 0, 0);
        commit_frame();
        e = exp_q.pop_front();
        checks++; if (cfg0 !== e) begin failures++; $display("FAIL abort_reload got=%h exp=%h", cfg0, e); end
        last_cfg = e;
    endtask

    task automatic test_reset_mid();
        logic [FL-1:0] d, e;
        drive_frame(mk_frame(rand_cfg()), 30, 0, 0);
        reset = 1'b1;
        @(negedge clk);
        checks++; if (cfg0 !== '0)     begin failures++; $display("FAIL rstmid_cfg got=%h exp=0", cfg0); end
        checks++; if (valid0 !== 1'b0) begin failures++; $display("FAIL rstmid_valid got=%b exp=0", valid0); end
        checks++; if (st0 !== 2'd0)    begin failures++; $display("FAIL rstmid_state got=%0d exp=0", st0); end
        checks++; if (cdo0 !== 1'b0)   begin failures++; $display("FAIL rstmid_cdo got=%b exp=0", cdo0); end
        reset = 1'b0;
        d = rand_cfg();
        exp_q.push_back(d);
        drive_frame(mk_frame(d), FW, 0, 0);
        commit_frame();
        e = exp_q.pop_front();
        checks++; if (cfg0 !== e) begin failures++; $display("FAIL rstmid_reload got=%h exp=%h", cfg0, e); end
        last_cfg = e;
    endtask

    task automatic test_back_to_back();
        logic [FL-1:0] e;
        for (int k = 0; k < 4; k++) begin
            exp_q.push_back(rand_cfg());
            drive_frame(mk_frame(exp_q[exp_q.size()-1]), FW, $urandom_range(0, FW), $urandom_range(1, 4));
            commit_frame();
            e = exp_q.pop_front();
            checks++; if (cfg0 !== e) begin failures++; $display("FAIL b2b_cfg[%0d] got=%h exp=%h", k, cfg0, e); end
            last_cfg = e;
        end
    endtask

`ifdef FRAME_PARITY_EN
    task automatic test_parity();
        logic [FL-1:0] d, e;
        logic [FW-1:0] f;
        do_reset();
        f = mk_frame(rand_cfg());
        f[0] = ~f[0];
        drive_frame(f, FW, 0, 0);
        checks++; if (err0 !== 1'b1) begin failures++; $display("FAIL parity_err got=%b exp=1", err0); end
        commit_frame();
        checks++; if (cfg0 !== '0)     begin failures++; $display("FAIL parity_shadow got=%h exp=0", cfg0); end
        checks++; if (valid0 !== 1'b0) begin failures++; $display("FAIL parity_valid got=%b exp=0", valid0); end
        d = rand_cfg();
        exp_q.push_back(d);
        drive_frame(mk_frame(d), FW, 0, 0);
        checks++; if (err0 !== 1'b0) begin failures++; $display("FAIL parity_ok_err got=%b exp=0", err0); end
        commit_frame();
        e = exp_q.pop_front();
        checks++; if (cfg0 !== e)      begin failures++; $display("FAIL parity_ok_cfg got=%h exp=%h", cfg0, e); end
        checks++; if (valid0 !== 1'b1) begin failures++; $display("FAIL parity_ok_valid got=%b exp=1", valid0); end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1, "simulation time limit reached");
    end

    initial begin
        chain_mode = 1'b0;
        last_cfg   = '0;
        @(negedge clk);
        test_reset();
        test_basic();
        test_chain();
        test_pause();
        test_abort();
        test_reset_mid();
        test_back_to_back();
`ifdef FRAME_PARITY_EN
        test_parity();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
